grf_wb_arbiter: RTL and testbench
=================================

Name: grf_wb_arbiter

Overview:
- Shares the single GRF write port between the pipeline W stage and one long-latency auxiliary requester, the multiply/divide result path (md).
- The W stage can never be stalled, so it always wins the port. md results wait in a small in-order buffer and drain into idle W slots.
- A starvation counter asks the hazard unit for bubbles. A pending-register mask lets the hazard unit hold readers of registers that are not yet written.

Parameters:
- DEPTH, 2: md buffer entries (1..4).
- MAX_WAIT, 4: cycles the head entry may wait before stall_req is raised (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- pipe_we  in  1  W-stage write enable (RegWrite_W)
- pipe_addr  in  5  W-stage destination register
- pipe_wd  in  32  W-stage write data
- md_valid  in  1  md result offered
- md_addr  in  5  md destination register
- md_wd  in  32  md result data
- md_ready  out  1  buffer can accept; a transfer happens when md_valid & md_ready
- grf_we  out  1  GRF write enable
- grf_addr  out  5  GRF write address
- grf_wd  out  32  GRF write data
- stall_req  out  1  request bubble insertion upstream
- pending_mask  out  32  bit i = a buffered write to register i exists
- buf_count  out  3  number of valid buffer entries

Behaviour:
- Reset (reset==0 at a clk edge): all entries invalid, wait counter 0.
  - Outputs in reset and immediately after: md_ready=1, grf_we=0, stall_req=0, pending_mask=0, buf_count=0.
- W slot busy: pipe_we==1 && pipe_addr!=0.
  - grf_* = pipe_* (combinational, zero latency).
- W slot idle and buffer non-empty:
  - grf_* = head entry; head pops at the clk edge.
  - The remaining entries shift toward the head and keep their order.
- Otherwise grf_we=0.
  - Writes to $0 never reach the port; pipe writes to $0 count as an idle slot.
- Enqueue:
  - Accepted entry lands at the tail at the clk edge. Earliest GRF write is the following cycle.
  - md_ready = (buf_count < DEPTH), computed from registered state only; it never looks ahead at a same-cycle pop.
  - An md transfer to $0 is accepted and discarded.
- WAW kill: when the W slot is busy with address A, every buffered entry with addr A is invalidated at that edge. The queue compacts in the same edge.
  - An md entry arriving in that same cycle with addr A is accepted and discarded; the pipeline write counts as newer.
- Simultaneous pop, kill and enqueue in one cycle are all legal. The final order is surviving old entries, then the new entry.
- Wait counter:
  - Clears on pop, on an empty buffer, and when the head entry is killed.
  - Otherwise increments while the head is valid and not popping, saturating at MAX_WAIT.
  - stall_req = head valid && counter==MAX_WAIT.
  - stall_req stays high until the pop edge and deasserts the cycle after.
- pending_mask and buf_count reflect registered state: the head still counts in the cycle it is being written.
- Reset mid-operation discards all buffered entries without writing them.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: if the buffer is empty, the W slot is idle, and md_valid with md_addr!=0 arrives, the md write goes straight to grf_* in the same cycle and is not enqueued (zero latency).
- Undefined: every md result passes through the buffer (minimum 1-cycle latency). md_ready and pending_mask are identical in both builds.

Decomposition:
- Shared package (mips_defs): GRF address width 5, data width 32, REG_ZERO constant, and a wb_entry struct (valid, addr[4:0], data[31:0]).
- One natural sub-module, wb_compact_queue: a DEPTH-entry shift queue with per-entry kill mask, pop, push and compaction, exporting buf_count and the entry array.
- The arbiter adds the port mux, the wait counter and the mask decode.

Test Plan:
- Reset, then md_valid, addr 8, wd 0x12345678, W idle. Required: cycle+1 grf_we=1, addr 8, data 0x12345678; pending_mask bit 8 set for exactly that one cycle.
- Fill 2 entries (addr 3, addr 4) while W writes every cycle. Required:
  - md_ready=0 at count 2.
  - stall_req rises after 4 waiting cycles.
  - First idle W slot writes addr 3, the next writes addr 4.
- Buffer holds addr 9 (0xAA). Then W writes addr 9 = 0xBB. Required: the entry is killed; no later write of 0xAA; final GRF[9]=0xBB; buf_count returns to 0.
- Same cycle: W writes addr 5 and md offers addr 5. Required: md accepted, buffer stays empty, only 0x(pipe data) written to $5.
- md offers addr 0 data 0xFFFFFFFF. Required: md_ready=1, nothing buffered, grf_we stays 0.
- With WB_BYPASS_EN: md addr 7, data 0x1, empty buffer, W idle. Required: grf_we=1 in the same cycle and buf_count stays 0. Without the macro, the write appears one cycle later.

Source files
------------

// File: rtl/grf_wb_arbiter_pkg.sv
// GRF write-back definitions: address/data widths, the zero register and the buffered md entry.
// Shared by the arbiter, its interface and the compaction queue.
package mips_defs;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry;

   function automatic logic [31:0] reg_bit(input logic [ADDR_W-1:0] a);
      reg_bit = 32'd1 << a;
   endfunction
endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle between the pipeline W stage / md unit and the GRF write-back arbiter.
// master = pipeline side driving requests, slave = the arbiter.
interface grf_wb_arbiter_if;
   import mips_defs::*;

   logic              pipe_we;
   logic [ADDR_W-1:0] pipe_addr;
   logic [DATA_W-1:0] pipe_wd;
   logic              md_valid;
   logic [ADDR_W-1:0] md_addr;
   logic [DATA_W-1:0] md_wd;
   logic              md_ready;
   logic              grf_we;
   logic [ADDR_W-1:0] grf_addr;
   logic [DATA_W-1:0] grf_wd;
   logic              stall_req;
   logic [31:0]       pending_mask;
   logic [2:0]        buf_count;

   modport master (
      output pipe_we, pipe_addr, pipe_wd, md_valid, md_addr, md_wd,
      input  md_ready, grf_we, grf_addr, grf_wd, stall_req, pending_mask, buf_count
   );

   modport slave (
      input  pipe_we, pipe_addr, pipe_wd, md_valid, md_addr, md_wd,
      output md_ready, grf_we, grf_addr, grf_wd, stall_req, pending_mask, buf_count
   );
endinterface

// File: rtl/grf_wb_arbiter_compact_queue.sv
// In-order shift queue: removes popped head and killed entries, compacts, then appends the push.
// One-edge update; caller guarantees push only when count < DEPTH.
module wb_compact_queue
   import mips_defs::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DEPTH-1:0]      kill,
   input  logic                  pop,
   input  logic                  push,
   input  wb_entry               push_entry,
   output wb_entry [DEPTH-1:0]   entries,
   output logic [2:0]            count
);
   wb_entry [DEPTH-1:0] ent_q, ent_d;
   logic [2:0]          cnt_q, cnt_d;

   // Survivors are packed toward slot 0 in original order; the new entry lands behind them.
   always_comb begin
      ent_d = '0;
      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid && !kill[i] && !(pop && i == 0)) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (cnt_d == 3'(j)) ent_d[j] = ent_q[i];
            end
            cnt_d = cnt_d + 3'd1;
         end
      end
      if (push && cnt_d < 3'(DEPTH)) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (cnt_d == 3'(j)) ent_d[j] = push_entry;
         end
         cnt_d = cnt_d + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ent_q <= '0;
         cnt_q <= '0;
      end else begin
         ent_q <= ent_d;
         cnt_q <= cnt_d;
      end
   end

   assign entries = ent_q;
   assign count   = cnt_q;
endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: W stage always wins, md results queue and drain into idle W slots.
// Zero-latency W writes, md >=1 cycle (0 with WB_BYPASS_EN); md_ready drops when the buffer is full.
module grf_wb_arbiter
   import mips_defs::*;
#(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic               clk,
   input  logic               reset,
   grf_wb_arbiter_if.slave    bus
);
   localparam int WW = $clog2(MAX_WAIT + 1);

   wb_entry [DEPTH-1:0] ents;
   wb_entry             head;
   wb_entry             push_entry;
   logic [2:0]          count;
   logic [DEPTH-1:0]    kill;
   logic                busy, ready, pop, push, bypass;
   logic                we_mux;
   logic [ADDR_W-1:0]   addr_mux;
   logic [DATA_W-1:0]   wd_mux;
   logic [31:0]         mask;
   logic [WW-1:0]       wait_q;

   assign head  = ents[0];
   assign busy  = bus.pipe_we && (bus.pipe_addr != REG_ZERO);
   assign ready = (count < 3'(DEPTH));
   assign pop   = !busy && head.valid;

`ifdef WB_BYPASS_EN
   assign bypass = !busy && (count == 3'd0) && bus.md_valid && (bus.md_addr != REG_ZERO);
`else
   assign bypass = 1'b0;
`endif

   // $0 targets and same-cycle W writes to the same register make the md result dead on arrival.
   assign push = bus.md_valid && ready && (bus.md_addr != REG_ZERO)
               && !(busy && bus.md_addr == bus.pipe_addr) && !bypass;
   assign push_entry = '{valid: 1'b1, addr: bus.md_addr, data: bus.md_wd};

   always_comb begin
      kill = '0;
      mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         kill[i] = busy && ents[i].valid && (ents[i].addr == bus.pipe_addr);
         if (ents[i].valid) mask = mask | reg_bit(ents[i].addr);
      end
   end

   wb_compact_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .reset      (reset),
      .kill       (kill),
      .pop        (pop),
      .push       (push),
      .push_entry (push_entry),
      .entries    (ents),
      .count      (count)
   );

   always_comb begin
      we_mux   = 1'b0;
      addr_mux = '0;
      wd_mux   = '0;
      if (busy) begin
         we_mux   = 1'b1;
         addr_mux = bus.pipe_addr;
         wd_mux   = bus.pipe_wd;
      end else if (head.valid) begin
         we_mux   = 1'b1;
         addr_mux = head.addr;
         wd_mux   = head.data;
      end else if (bypass) begin
         we_mux   = 1'b1;
         addr_mux = bus.md_addr;
         wd_mux   = bus.md_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_q <= '0;
      end else if (pop || !head.valid || kill[0]) begin
         wait_q <= '0;
      end else if (wait_q != WW'(MAX_WAIT)) begin
         wait_q <= wait_q + WW'(1);
      end
   end

   // Reset forces the idle output pattern even before the first clock edge.
   assign bus.md_ready     = !reset || ready;
   assign bus.grf_we       = reset && we_mux;
   assign bus.grf_addr     = addr_mux;
   assign bus.grf_wd       = wd_mux;
   assign bus.stall_req    = reset && head.valid && (wait_q == WW'(MAX_WAIT));
   assign bus.pending_mask = reset ? mask : 32'd0;
   assign bus.buf_count    = reset ? count : 3'd0;
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed plus random checks of grf_wb_arbiter against a queue-based reference model.
module tb_grf_wb_arbiter;
   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ment_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   ment_t       q[$];
   int          w = 0;
   logic [31:0] grf_sh [32];

   grf_wb_arbiter_if bus ();

   grf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
      bus.pipe_we   = we;
      bus.pipe_addr = pa;
      bus.pipe_wd   = pd;
      bus.md_valid  = mv;
      bus.md_addr   = ma;
      bus.md_wd     = md;
   endtask

   task automatic rst_cycle();
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #2;
      chk("rst_md_ready", bus.md_ready, 1);
      chk("rst_grf_we", bus.grf_we, 0);
      chk("rst_stall", bus.stall_req, 0);
      chk("rst_mask", bus.pending_mask, 0);
      chk("rst_count", bus.buf_count, 0);
      q.delete();
      w = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // One clock of stimulus: drive, compare against the model, advance the model, clock.
   task automatic step(input logic we, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
      bit          busy, ready, byp, had, hk, popped, exp_we;
      logic [4:0]  ea;
      logic [31:0] ed, em;
      drive(we, pa, pd, mv, ma, md);
      #2;
      busy  = we && pa != 5'd0;
      ready = q.size() < DEPTH;
      had   = q.size() > 0;
      byp   = BYP && !busy && !had && mv && ma != 5'd0;
      em = 32'd0;
      foreach (q[i]) em = em | (32'd1 << q[i].a);
      exp_we = 1'b1;
      ea = 5'd0;
      ed = 32'd0;
      if (busy) begin
         ea = pa; ed = pd;
      end else if (had) begin
         ea = q[0].a; ed = q[0].d;
      end else if (byp) begin
         ea = ma; ed = md;
      end else begin
         exp_we = 1'b0;
      end
      chk("md_ready", bus.md_ready, ready);
      chk("buf_count", bus.buf_count, q.size());
      chk("pending_mask", bus.pending_mask, em);
      chk("stall_req", bus.stall_req, had && w == MAX_WAIT);
      chk("grf_we", bus.grf_we, exp_we);
      if (exp_we) begin
         chk("grf_addr", bus.grf_addr, ea);
         chk("grf_wd", bus.grf_wd, ed);
      end
      if (bus.grf_we === 1'b1) grf_sh[bus.grf_addr] = bus.grf_wd;

      popped = !busy && had;
      hk     = busy && had && q[0].a == pa;
      if (popped) void'(q.pop_front());
      if (busy)
         for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a == pa) q.delete(i);
      if (mv && ready && ma != 5'd0 && !(busy && ma == pa) && !byp)
         q.push_back('{a: ma, d: md});
      if (popped || hk || !had) w = 0;
      else if (w < MAX_WAIT) w = w + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      foreach (grf_sh[i]) grf_sh[i] = 32'd0;
      rst_cycle();
      rst_cycle();

      // Single md write drains one cycle after acceptance.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h12345678);
      chk("t1_count", bus.buf_count, BYP ? 0 : 1);
      chk("t1_mask", bus.pending_mask, BYP ? 32'd0 : 32'h0000_0100);
      idle();
      chk("t1_mask_clear", bus.pending_mask, 0);
      chk("t1_grf8", grf_sh[8], 32'h12345678);

      // Fill under a continuously busy W stage until stall_req rises.
      step(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
      step(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
      chk("t2_full_ready", bus.md_ready, 0);
      chk("t2_count", bus.buf_count, 2);
      for (int k = 0; k < 3; k++) step(1'b1, 5'd1 + 5'(k % 2), 32'h100 + k, 1'b0, 5'd0, 32'd0);
      chk("t2_stall", bus.stall_req, 1);
      idle();
      chk("t2_grf3", grf_sh[3], 32'h33);
      idle();
      chk("t2_grf4", grf_sh[4], 32'h44);
      chk("t2_stall_drop", bus.stall_req, 0);

      // WAW kill of a buffered entry.
      step(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hAA);
      step(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0);
      chk("t3_count", bus.buf_count, 0);
      idle();
      idle();
      chk("t3_grf9", grf_sh[9], 32'hBB);

      // Same-cycle W and md to the same register.
      step(1'b1, 5'd5, 32'hC0DE5, 1'b1, 5'd5, 32'h55);
      chk("t4_count", bus.buf_count, 0);
      idle();
      chk("t4_grf5", grf_sh[5], 32'hC0DE5);

      // md to $0 is swallowed.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
      chk("t5_count", bus.buf_count, 0);

      // Bypass path (or one-cycle buffered path in the default build).
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1);
      chk("t6_count", bus.buf_count, BYP ? 0 : 1);
      idle();
      chk("t6_grf7", grf_sh[7], 32'h1);

      // Reset with entries buffered discards them.
      step(1'b1, 5'd1, 32'h2, 1'b1, 5'd12, 32'hDEAD);
      step(1'b1, 5'd1, 32'h3, 1'b1, 5'd13, 32'hBEEF);
      rst_cycle();
      idle();
      idle();
      chk("t7_grf12", grf_sh[12], 32'd0);

      // Randomized traffic over a small register range to provoke kills.
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end
      for (int k = 0; k < 4; k++) idle();
      chk("final_count", bus.buf_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
